dma_multichannel_copy: RTL and testbench

Parametrised multi-channel successor to the single-task RAM/HDD copy engine. It holds up to CHANNELS independent copy descriptors. Each descriptor carries a direction, a program-RAM base, an HDD base and a cell count. Active descriptors are served one at a time under round-robin arbitration, at one cell per clock. It sits between the CPU-side DMA instruction decode (REQFRAM/REQFHDD-style requests) and the pram/hdd memory ports, and reports per-channel busy and completion status back for write-back.

---
 rtl/dma_pkg.sv | 26 ++
 rtl/dma_multichannel_copy_if.sv | 39 +++
 rtl/dma_rr_arbiter.sv | 26 ++
 rtl/dma_multichannel_copy.sv | 202 ++++++++++++++++++++
 tb/tb_dma_multichannel_copy.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// Shared types for the multi-channel copy engine: FSM states, copy directions
// and the per-slot descriptor layout.
package dma_pkg;

  localparam int DESC_ADDR_W = 16;
  localparam int DESC_CNT_W  = 16;

  localparam logic DIR_RAM2HDD = 1'b0;
  localparam logic DIR_HDD2RAM = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COPY  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } dma_state_e;

  // Field widths are fixed here; ADDR_W/CNT_W on the top must match them.
  typedef struct packed {
    logic                   dir;
    logic [DESC_ADDR_W-1:0] ram_pos;
    logic [DESC_ADDR_W-1:0] hdd_pos;
    logic [DESC_CNT_W-1:0]  count;
  } desc_t;

endpackage

// File: rtl/dma_multichannel_copy_if.sv
// CPU-side request / cancel / completion bundle of the copy engine.
interface dma_multichannel_copy_if #(
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2,
  parameter int ADDR_W   = 16,
  parameter int CNT_W    = 16
);
  // A descriptor transfers on a clock edge where req_valid && req_accept;
  // cancel and done are single-cycle strobes with no back-pressure.
  logic                req_valid;
  logic [CH_W-1:0]     req_chan;
  logic                req_dir;
  logic [ADDR_W-1:0]   req_ram_pos;
  logic [ADDR_W-1:0]   req_hdd_pos;
  logic [CNT_W-1:0]    req_count;
  logic                req_accept;
  logic                cancel_valid;
  logic [CH_W-1:0]     cancel_chan;
  logic [CHANNELS-1:0] chan_busy;
  logic                engine_busy;
  logic                done_valid;
  logic [CH_W-1:0]     done_chan;
  logic                done_aborted;
  logic [CNT_W-1:0]    done_cells;

  modport slave (
    input  req_valid, req_chan, req_dir, req_ram_pos, req_hdd_pos, req_count,
    input  cancel_valid, cancel_chan,
    output req_accept, chan_busy, engine_busy,
    output done_valid, done_chan, done_aborted, done_cells
  );

  modport master (
    output req_valid, req_chan, req_dir, req_ram_pos, req_hdd_pos, req_count,
    output cancel_valid, cancel_chan,
    input  req_accept, chan_busy, engine_busy,
    input  done_valid, done_chan, done_aborted, done_cells
  );
endinterface

// File: rtl/dma_rr_arbiter.sv
// Round-robin pick: lowest requesting slot at or after ptr, wrapping around.
module dma_rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int CH_W     = 2
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CH_W-1:0]     ptr,
  output logic                grant_valid,
  output logic [CH_W-1:0]     grant_idx
);
  logic [CH_W-1:0] idx;

  // Scan from farthest to nearest so the nearest requester is written last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      idx = ptr + CH_W'(i);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end
endmodule

// File: rtl/dma_multichannel_copy.sv
// Multi-slot RAM/HDD copy engine: round-robin over loaded descriptors,
// one cell per clock, with cancel and per-slot completion reporting.
module dma_multichannel_copy
  import dma_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = DESC_ADDR_W,
  parameter int CNT_W    = DESC_CNT_W,
  parameter int CHANNELS = 4,
  parameter int CH_W     = $clog2(CHANNELS)
) (
  input  logic              clock,
  input  logic              init_flag,
  dma_multichannel_copy_if.slave host,
  output logic [ADDR_W-1:0] pram_addr,
  input  logic [DATA_W-1:0] pram_rd_data,
  output logic              pram_wr_en,
  output logic [DATA_W-1:0] pram_wr_data,
  output logic [ADDR_W-1:0] hdd_addr,
  input  logic [DATA_W-1:0] hdd_rd_data,
  output logic              hdd_wr_en,
  output logic [DATA_W-1:0] hdd_wr_data,
  output dma_state_e        dbg_state
);
  dma_state_e          state_q, state_d;
  desc_t               slot_q [CHANNELS];
  desc_t               slot_d [CHANNELS];
  logic [CHANNELS-1:0] busy_q, busy_d, abort_pend_q, abort_pend_d;
  logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d, act_chan_q, act_chan_d;
  logic                act_dir_q, act_dir_d, aborted_q, aborted_d;
  logic                abort_only_q, abort_only_d, pipe_valid_q, pipe_valid_d;
  logic [ADDR_W-1:0]   src_base_q, src_base_d, dst_base_q, dst_base_d;
  logic [ADDR_W-1:0]   pipe_dst_q, pipe_dst_d;
  logic [CNT_W-1:0]    count_q, count_d, rd_idx_q, rd_idx_d, wr_cnt_q, wr_cnt_d;

  logic                grant_valid, act_live, cancel_active, cancel_pending, wr_en;
  logic [CH_W-1:0]     grant_idx;
  logic [ADDR_W-1:0]   src_addr;
  logic [DATA_W-1:0]   src_rd;
  desc_t               gdesc;

  dma_rr_arbiter #(.CHANNELS(CHANNELS), .CH_W(CH_W)) u_arb (
    .req        (busy_q | abort_pend_q),
    .ptr        (rr_ptr_q),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  assign gdesc    = slot_q[grant_idx];
  // An abort-only pass through DONE owns no slot, so it is never "active".
  assign act_live = (state_q != ST_IDLE) && !abort_only_q;
  assign cancel_active  = host.cancel_valid && act_live && (host.cancel_chan == act_chan_q);
  assign cancel_pending = host.cancel_valid && busy_q[host.cancel_chan] &&
                          !(act_live && (host.cancel_chan == act_chan_q));

  assign host.req_accept = host.req_valid && !busy_q[host.req_chan] && init_flag &&
                           !(host.cancel_valid && (host.cancel_chan == host.req_chan));

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    busy_d       = busy_q;
    abort_pend_d = abort_pend_q;
    rr_ptr_d     = rr_ptr_q;
    act_chan_d   = act_chan_q;
    act_dir_d    = act_dir_q;
    aborted_d    = aborted_q;
    abort_only_d = abort_only_q;
    src_base_d   = src_base_q;
    dst_base_d   = dst_base_q;
    count_d      = count_q;
    rd_idx_d     = rd_idx_q;
    wr_cnt_d     = wr_cnt_q;
    pipe_valid_d = 1'b0;
    pipe_dst_d   = pipe_dst_q;

    if (cancel_pending) begin
      busy_d[host.cancel_chan]       = 1'b0;
      abort_pend_d[host.cancel_chan] = 1'b1;
    end
    if (host.req_accept) begin
      slot_d[host.req_chan] = '{dir: host.req_dir,
                                ram_pos: DESC_ADDR_W'(host.req_ram_pos),
                                hdd_pos: DESC_ADDR_W'(host.req_hdd_pos),
                                count: DESC_CNT_W'(host.req_count)};
      busy_d[host.req_chan] = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: if (grant_valid) begin
        rr_ptr_d   = grant_idx + CH_W'(1);
        act_chan_d = grant_idx;
        rd_idx_d   = '0;
        wr_cnt_d   = '0;
        if (abort_pend_q[grant_idx] || (cancel_pending && host.cancel_chan == grant_idx)) begin
          abort_pend_d[grant_idx] = 1'b0;
          aborted_d    = 1'b1;
          abort_only_d = 1'b1;
          state_d      = ST_DONE;
        end else begin
          aborted_d    = 1'b0;
          abort_only_d = 1'b0;
          act_dir_d    = gdesc.dir;
          count_d      = CNT_W'(gdesc.count);
          src_base_d   = (gdesc.dir == DIR_HDD2RAM) ? ADDR_W'(gdesc.hdd_pos) : ADDR_W'(gdesc.ram_pos);
          dst_base_d   = (gdesc.dir == DIR_HDD2RAM) ? ADDR_W'(gdesc.ram_pos) : ADDR_W'(gdesc.hdd_pos);
          state_d      = (gdesc.count == '0) ? ST_DONE : ST_COPY;
        end
      end
      ST_COPY: begin
        if (pipe_valid_q) wr_cnt_d = wr_cnt_q + CNT_W'(1);
        // On cancel the read issued this cycle is discarded, not written.
        if (cancel_active) begin
          aborted_d = 1'b1;
          state_d   = ST_DRAIN;
        end else begin
          pipe_valid_d = 1'b1;
          pipe_dst_d   = dst_base_q + ADDR_W'(rd_idx_q);
          rd_idx_d     = rd_idx_q + CNT_W'(1);
          if (rd_idx_q == count_q - CNT_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pipe_valid_q) wr_cnt_d = wr_cnt_q + CNT_W'(1);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!abort_only_q) busy_d[act_chan_q] = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!init_flag) begin
      state_q      <= ST_IDLE;
      slot_q       <= '{default: '0};
      busy_q       <= '0;
      abort_pend_q <= '0;
      rr_ptr_q     <= '0;
      act_chan_q   <= '0;
      act_dir_q    <= 1'b0;
      aborted_q    <= 1'b0;
      abort_only_q <= 1'b0;
      src_base_q   <= '0;
      dst_base_q   <= '0;
      count_q      <= '0;
      rd_idx_q     <= '0;
      wr_cnt_q     <= '0;
      pipe_valid_q <= 1'b0;
      pipe_dst_q   <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      busy_q       <= busy_d;
      abort_pend_q <= abort_pend_d;
      rr_ptr_q     <= rr_ptr_d;
      act_chan_q   <= act_chan_d;
      act_dir_q    <= act_dir_d;
      aborted_q    <= aborted_d;
      abort_only_q <= abort_only_d;
      src_base_q   <= src_base_d;
      dst_base_q   <= dst_base_d;
      count_q      <= count_d;
      rd_idx_q     <= rd_idx_d;
      wr_cnt_q     <= wr_cnt_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_dst_q   <= pipe_dst_d;
    end
  end

  assign src_addr = src_base_q + ADDR_W'(rd_idx_q);
  assign wr_en    = ((state_q == ST_COPY) || (state_q == ST_DRAIN)) && pipe_valid_q;
  assign src_rd   = (act_dir_q == DIR_HDD2RAM) ? hdd_rd_data : pram_rd_data;

  always_comb begin
    pram_addr = '0;
    hdd_addr  = '0;
    if (state_q == ST_COPY) begin
      if (act_dir_q == DIR_RAM2HDD) pram_addr = src_addr;
      else                          hdd_addr  = src_addr;
    end
    if (wr_en) begin
      if (act_dir_q == DIR_RAM2HDD) hdd_addr  = pipe_dst_q;
      else                          pram_addr = pipe_dst_q;
    end
  end

  assign pram_wr_en   = wr_en && (act_dir_q == DIR_HDD2RAM);
  assign hdd_wr_en    = wr_en && (act_dir_q == DIR_RAM2HDD);
  assign pram_wr_data = pram_wr_en ? src_rd : '0;
  assign hdd_wr_data  = hdd_wr_en ? src_rd : '0;

  assign host.chan_busy    = busy_q;
  assign host.engine_busy  = (state_q != ST_IDLE);
  assign host.done_valid   = (state_q == ST_DONE);
  assign host.done_chan    = (state_q == ST_DONE) ? act_chan_q : '0;
  assign host.done_aborted = (state_q == ST_DONE) && aborted_q;
  assign host.done_cells   = (state_q == ST_DONE) ? wr_cnt_q : '0;
  assign dbg_state         = state_q;
endmodule

// File: tb/tb_dma_multichannel_copy.sv
// Directed bench for dma_multichannel_copy: expected writes and completions
// are queued at stimulus time and popped by a negedge monitor.
module tb_dma_multichannel_copy;
  import dma_pkg::*;

  localparam int DATA_W = 32, ADDR_W = 16, CNT_W = 16, CHANNELS = 4, CH_W = 2;
  localparam int WR_W = 1 + ADDR_W + DATA_W;
  localparam int DN_W = CH_W + 1 + CNT_W;

  // clock / reset
  logic clock = 1'b0;
  logic init_flag = 1'b0;
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [ADDR_W-1:0] pram_addr, hdd_addr;
  logic [DATA_W-1:0] pram_rd_data = '0, hdd_rd_data = '0;
  logic [DATA_W-1:0] pram_wr_data, hdd_wr_data;
  logic              pram_wr_en, hdd_wr_en;
  dma_state_e        dbg_state;

  dma_multichannel_copy_if #(.CHANNELS(CHANNELS), .CH_W(CH_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) host ();

  dma_multichannel_copy #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .CHANNELS(CHANNELS)) dut (
    .clock(clock), .init_flag(init_flag), .host(host),
    .pram_addr(pram_addr), .pram_rd_data(pram_rd_data), .pram_wr_en(pram_wr_en), .pram_wr_data(pram_wr_data),
    .hdd_addr(hdd_addr), .hdd_rd_data(hdd_rd_data), .hdd_wr_en(hdd_wr_en), .hdd_wr_data(hdd_wr_data),
    .dbg_state(dbg_state)
  );

  // Memories return an address-tagged word one cycle after the address.
  always @(posedge clock) begin
    pram_rd_data <= {16'hA0A0, pram_addr};
    hdd_rd_data  <= {16'hB0B0, hdd_addr};
  end

  // scoreboard
  logic [WR_W-1:0] exp_wr_q[$];
  logic [DN_W-1:0] exp_done_q[$];
  int checks = 0, failures = 0;
  int last_done_cyc = 0, last_acc_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_write(input logic port, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (exp_wr_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL write_unexpected: got port=%0d addr=0x%0h data=0x%0h expected none", port, a, d);
    end else check("write", {port, a, d}, exp_wr_q.pop_front());
  endtask

  always @(negedge clock) begin
    if (pram_wr_en) mon_write(1'b0, pram_addr, pram_wr_data);
    if (hdd_wr_en)  mon_write(1'b1, hdd_addr, hdd_wr_data);
    if (host.done_valid) begin
      last_done_cyc = cyc;
      if (exp_done_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL done_unexpected: got chan=%0d aborted=%0d cells=%0d expected none",
                 host.done_chan, host.done_aborted, host.done_cells);
      end else check("done", {host.done_chan, host.done_aborted, host.done_cells}, exp_done_q.pop_front());
    end
  end

  // expected-value helpers: dir 0 writes hdd with pram data, dir 1 the reverse
  task automatic push_writes(input logic dir, input logic [ADDR_W-1:0] ram, input logic [ADDR_W-1:0] hdd, input int n);
    logic [ADDR_W-1:0] r, h;
    for (int k = 0; k < n; k++) begin
      r = ram + ADDR_W'(k);
      h = hdd + ADDR_W'(k);
      if (dir) exp_wr_q.push_back({1'b0, r, 16'hB0B0, h});
      else     exp_wr_q.push_back({1'b1, h, 16'hA0A0, r});
    end
  endtask

  task automatic push_done(input logic [CH_W-1:0] ch, input logic ab, input logic [CNT_W-1:0] cells);
    exp_done_q.push_back({ch, ab, cells});
  endtask

  // driver tasks
  task automatic send_req(input logic [CH_W-1:0] ch, input logic dir, input logic [ADDR_W-1:0] ram,
                          input logic [ADDR_W-1:0] hdd, input logic [CNT_W-1:0] cnt,
                          input logic exp_acc, input string name);
    @(posedge clock); #1;
    host.req_chan = ch; host.req_dir = dir; host.req_ram_pos = ram;
    host.req_hdd_pos = hdd; host.req_count = cnt; host.req_valid = 1'b1;
    @(negedge clock);
    check(name, host.req_accept, exp_acc);
    last_acc_cyc = cyc;
    @(posedge clock); #1;
    host.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge clock); n++; end
    while ((host.engine_busy || host.chan_busy != '0 || exp_wr_q.size() != 0 || exp_done_q.size() != 0) && n < 400);
    check({name, "_complete"}, n < 400, 1'b1);
  endtask

  initial begin
    int n;
    host.req_valid = 1'b0; host.req_chan = '0; host.req_dir = 1'b0;
    host.req_ram_pos = '0; host.req_hdd_pos = '0; host.req_count = '0;
    host.cancel_valid = 1'b0; host.cancel_chan = '0;

    // reset: all outputs zero, requests refused
    init_flag = 1'b0;
    host.req_valid = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_accept", host.req_accept, 1'b0);
    check("rst_chan_busy", host.chan_busy, 4'h0);
    check("rst_engine_busy", host.engine_busy, 1'b0);
    check("rst_done_valid", host.done_valid, 1'b0);
    check("rst_wr_en", {pram_wr_en, hdd_wr_en}, 2'b00);
    check("rst_addr", {pram_addr, hdd_addr}, 32'h0);
    check("rst_wr_data", {pram_wr_data, hdd_wr_data}, 64'h0);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge clock); #1;
    host.req_valid = 1'b0;
    init_flag = 1'b1;

    // single copy hdd->pram, latency from accept
    push_writes(1'b1, 16'h0100, 16'h0200, 4);
    push_done(2'd0, 1'b0, 16'd4);
    send_req(2'd0, 1'b1, 16'h0100, 16'h0200, 16'd4, 1'b1, "single_accept");
    @(negedge clock);
    check("single_busy", host.chan_busy, 4'b0001);
    n = last_acc_cyc;
    wait_idle("single");
    check("single_latency", last_done_cyc - n, 7);

    // pram address wraps past 0xFFFF
    push_writes(1'b0, 16'hFFFE, 16'h0010, 4);
    push_done(2'd1, 1'b0, 16'd4);
    send_req(2'd1, 1'b0, 16'hFFFE, 16'h0010, 16'd4, 1'b1, "wrap_accept");
    wait_idle("wrap");

    // round robin: ch1..3 loaded during ch0, ch0 reloaded after ch1 grant
    push_writes(1'b0, 16'h2000, 16'h1000, 8); push_done(2'd0, 1'b0, 16'd8);
    push_writes(1'b1, 16'h2100, 16'h1100, 2); push_done(2'd1, 1'b0, 16'd2);
    push_writes(1'b0, 16'h2200, 16'h1200, 2); push_done(2'd2, 1'b0, 16'd2);
    push_writes(1'b1, 16'h2300, 16'h1300, 2); push_done(2'd3, 1'b0, 16'd2);
    push_writes(1'b0, 16'h2400, 16'h1400, 3); push_done(2'd0, 1'b0, 16'd3);
    send_req(2'd0, 1'b0, 16'h2000, 16'h1000, 16'd8, 1'b1, "rr_ch0");
    send_req(2'd1, 1'b1, 16'h2100, 16'h1100, 16'd2, 1'b1, "rr_ch1");
    send_req(2'd2, 1'b0, 16'h2200, 16'h1200, 16'd2, 1'b1, "rr_ch2");
    send_req(2'd3, 1'b1, 16'h2300, 16'h1300, 16'd2, 1'b1, "rr_ch3");
    n = 0;
    do begin @(negedge clock); n++; end while (host.chan_busy[0] && n < 100);
    check("rr_ch0_free", host.chan_busy[0], 1'b0);
    send_req(2'd0, 1'b0, 16'h2400, 16'h1400, 16'd3, 1'b1, "rr_ch0_again");
    wait_idle("rr");

    // busy slot rejects a second descriptor and keeps the first
    push_writes(1'b1, 16'h0900, 16'h0A00, 6); push_done(2'd0, 1'b0, 16'd6);
    push_writes(1'b0, 16'h0B00, 16'h0C00, 2); push_done(2'd2, 1'b0, 16'd2);
    send_req(2'd0, 1'b1, 16'h0900, 16'h0A00, 16'd6, 1'b1, "rej_ch0");
    send_req(2'd2, 1'b0, 16'h0B00, 16'h0C00, 16'd2, 1'b1, "rej_ch2_first");
    send_req(2'd2, 1'b1, 16'h0D00, 16'h0E00, 16'd3, 1'b0, "rej_ch2_second");
    wait_idle("reject");

    // cancel the active slot while write 3 is on the bus
    push_writes(1'b1, 16'h0300, 16'h0400, 4); push_done(2'd0, 1'b1, 16'd4);
    send_req(2'd0, 1'b1, 16'h0300, 16'h0400, 16'd10, 1'b1, "cact_accept");
    n = 0;
    do begin @(negedge clock); n++; end while (!(pram_wr_en && pram_addr == 16'h0303) && n < 100);
    check("cact_seen_write3", n < 100, 1'b1);
    host.cancel_chan = 2'd0; host.cancel_valid = 1'b1;
    @(posedge clock); #1;
    host.cancel_valid = 1'b0;
    wait_idle("cancel_active");

    // cancel a pending slot, then cancel+accept collision on an idle slot
    push_writes(1'b0, 16'h0700, 16'h0800, 6); push_done(2'd0, 1'b0, 16'd6);
    push_done(2'd3, 1'b1, 16'd0);
    send_req(2'd0, 1'b0, 16'h0700, 16'h0800, 16'd6, 1'b1, "cpend_ch0");
    send_req(2'd3, 1'b1, 16'h0750, 16'h0850, 16'd5, 1'b1, "cpend_ch3");
    host.cancel_chan = 2'd3; host.cancel_valid = 1'b1;
    @(posedge clock); #1;
    host.cancel_valid = 1'b0;
    @(negedge clock);
    check("cpend_busy_cleared", host.chan_busy[3], 1'b0);
    @(posedge clock); #1;
    host.req_chan = 2'd1; host.req_dir = 1'b0; host.req_count = 16'd2; host.req_valid = 1'b1;
    host.cancel_chan = 2'd1; host.cancel_valid = 1'b1;
    @(negedge clock);
    check("cancel_beats_accept", host.req_accept, 1'b0);
    @(posedge clock); #1;
    host.req_valid = 1'b0; host.cancel_valid = 1'b0;
    wait_idle("cancel_pending");

    // zero-count descriptor completes one cycle after grant
    push_done(2'd2, 1'b0, 16'd0);
    send_req(2'd2, 1'b0, 16'h0000, 16'h0000, 16'd0, 1'b1, "zero_accept");
    n = last_acc_cyc;
    wait_idle("zero");
    check("zero_latency", last_done_cyc - n, 2);

    // reset in the middle of a copy
    push_writes(1'b0, 16'h0500, 16'h0600, 20); push_done(2'd1, 1'b0, 16'd20);
    send_req(2'd1, 1'b0, 16'h0500, 16'h0600, 16'd20, 1'b1, "mrst_accept");
    n = 0;
    do begin @(negedge clock); n++; end while (!(hdd_wr_en && hdd_addr == 16'h0605) && n < 100);
    check("mrst_seen_write5", n < 100, 1'b1);
    @(posedge clock); #1;
    init_flag = 1'b0;
    @(posedge clock); #1;
    exp_wr_q.delete();
    exp_done_q.delete();
    @(negedge clock);
    check("mrst_wr_en", {pram_wr_en, hdd_wr_en}, 2'b00);
    check("mrst_chan_busy", host.chan_busy, 4'h0);
    check("mrst_engine_busy", host.engine_busy, 1'b0);
    @(posedge clock); #1;
    init_flag = 1'b1;
    repeat (30) @(negedge clock);
    check("mrst_no_done_left", exp_done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
